dotprod_l2_cxu: RTL and testbench



---
 rtl/cxu_pkg.sv | 40 ++++
 rtl/dotprod_lanes.sv | 37 +++
 rtl/dotprod_l2_cxu.sv | 234 +++++++++++++++++++++++
 tb/tb_dotprod_l2_cxu.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cxu_pkg.sv
// rtl/cxu_pkg.sv - shared CXU-L2 types, status codes and standard function IDs
package cxu_pkg;

  localparam int CXU_CFID_W = 10;

  typedef logic [CXU_CFID_W-1:0] cfid_t;

  typedef enum logic [1:0] {
    CXU_OK          = 2'd0,
    CXU_ERROR_FUNC  = 2'd1,
    CXU_ERROR_STATE = 2'd2,
    CXU_ERROR_OFF   = 2'd3
  } cxu_status_t;

  typedef enum logic [1:0] {
    CXU_CS_OFF   = 2'd0,
    CXU_CS_INIT  = 2'd1,
    CXU_CS_CLEAN = 2'd2,
    CXU_CS_DIRTY = 2'd3
  } cxu_cs_t;

  typedef struct packed {
    logic [9:0] state_size;
    cxu_cs_t    cs;
  } cxu_csw_t;

  localparam cfid_t CXU_CFID_WRITE_STATE  = cfid_t'(1020);
  localparam cfid_t CXU_CFID_READ_STATE   = cfid_t'(1021);
  localparam cfid_t CXU_CFID_WRITE_STATUS = cfid_t'(1022);
  localparam cfid_t CXU_CFID_READ_STATUS  = cfid_t'(1023);

  // Every context of a block holds one accumulator word, so state_size is 1.
  function automatic cxu_csw_t make_csw(input cxu_cs_t cs);
    cxu_csw_t w;
    w.state_size = 10'd1;
    w.cs         = cs;
    return w;
  endfunction

endpackage

// File: rtl/dotprod_lanes.sv
// rtl/dotprod_lanes.sv - one beat of LANES signed/unsigned element products, summed
module dotprod_lanes #(
  parameter int ELEM_W     = 8,
  parameter int LANES      = 2,
  parameter int CXU_DATA_W = 32
) (
  input  logic                      is_signed,
  input  logic [LANES*ELEM_W-1:0]   a,
  input  logic [LANES*ELEM_W-1:0]   b,
  output logic [CXU_DATA_W-1:0]     sum
);

  localparam int PW = 2*ELEM_W + 2;
  localparam int XW = (PW > CXU_DATA_W) ? PW : CXU_DATA_W;

  logic signed [ELEM_W:0] ea;
  logic signed [ELEM_W:0] eb;
  logic signed [PW-1:0]   prod;
  logic [XW-1:0]          acc;

  // One extra operand bit carries the sign (or zero) so a single signed
  // multiplier covers both modes; the size cast then sign-extends the product.
  always_comb begin
    acc  = '0;
    ea   = '0;
    eb   = '0;
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      ea   = {is_signed & a[i*ELEM_W+ELEM_W-1], a[i*ELEM_W +: ELEM_W]};
      eb   = {is_signed & b[i*ELEM_W+ELEM_W-1], b[i*ELEM_W +: ELEM_W]};
      prod = ea * eb;
      acc  = acc + XW'(prod);
    end
    sum = acc[CXU_DATA_W-1:0];
  end

endmodule

// File: rtl/dotprod_l2_cxu.sv
// rtl/dotprod_l2_cxu.sv - multi-context, multi-beat dot-product CXU with L2 handshakes
module dotprod_l2_cxu
  import cxu_pkg::*;
#(
  parameter int CXU_N_CXUS     = 1,
  parameter int CXU_N_STATES   = 4,
  parameter int CXU_FUNC_ID_W  = 10,
  parameter int CXU_DATA_W     = 32,
  parameter int ELEM_W         = 8,
  parameter int LANES          = 2,
  parameter int CXU_CXU_ID_W   = (CXU_N_CXUS > 1) ? $clog2(CXU_N_CXUS) : 1,
  parameter int CXU_STATE_ID_W = (CXU_N_STATES > 1) ? $clog2(CXU_N_STATES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CXU_CXU_ID_W-1:0]   req_cxu,
  input  logic [CXU_STATE_ID_W-1:0] req_state,
  input  logic [CXU_FUNC_ID_W-1:0]  req_func,
  input  logic [CXU_DATA_W-1:0]     req_data0,
  input  logic [CXU_DATA_W-1:0]     req_data1,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output cxu_status_t               resp_status,
  output logic [CXU_DATA_W-1:0]     resp_data
);

  localparam int E      = CXU_DATA_W / ELEM_W;
  localparam int B      = E / LANES;
  localparam int LW     = LANES * ELEM_W;
  localparam int BEAT_W = (B > 1) ? $clog2(B) : 1;
  localparam int IDX_W  = (CXU_N_STATES > 1) ? $clog2(CXU_N_STATES) : 1;
  localparam int CSW_W  = $bits(cxu_csw_t);

  typedef enum logic [1:0] {
    DP_UNSIGNED     = 2'd0,
    DP_ACC_UNSIGNED = 2'd1,
    DP_SIGNED       = 2'd2,
    DP_ACC_SIGNED   = 2'd3
  } dotprod_cfid_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_RESP = 2'd2
  } fsm_e;

  fsm_e                  state_q, state_d;
  dotprod_cfid_t         dp_q, dp_d;
  logic [IDX_W-1:0]      ctx_q, ctx_d;
  logic [CXU_DATA_W-1:0] data0_q, data0_d;
  logic [CXU_DATA_W-1:0] data1_q, data1_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CXU_DATA_W-1:0] sum_q, sum_d;
  cxu_status_t           resp_status_q, resp_status_d;
  logic [CXU_DATA_W-1:0] resp_data_q, resp_data_d;
  cxu_cs_t               cs_q [CXU_N_STATES];
  cxu_cs_t               cs_d [CXU_N_STATES];
  logic [CXU_N_STATES-1:0] zacc_q, zacc_d;

  logic [CXU_DATA_W-1:0] acc_q [CXU_N_STATES];
  logic                  acc_we;
  logic [IDX_W-1:0]      acc_waddr;
  logic [CXU_DATA_W-1:0] acc_wdata;

  cfid_t                 req_cfid;
  logic                  state_ok;
  logic [IDX_W-1:0]      rd_idx;
  logic [CXU_DATA_W-1:0] acc_rd;
  cxu_cs_t               new_cs;
  logic                  lane_signed;
  logic [LW-1:0]         lane_a, lane_b;
  logic [CXU_DATA_W-1:0] lane_sum;
  logic [CXU_DATA_W-1:0] mac_result;
  logic                  unused_req_cxu;

  assign unused_req_cxu = ^req_cxu;

  assign req_cfid = cfid_t'(req_func);
  assign state_ok = int'(req_state) < CXU_N_STATES;
  assign rd_idx   = state_ok ? IDX_W'(req_state) : '0;
  assign acc_rd   = zacc_q[rd_idx] ? '0 : acc_q[rd_idx];
  assign new_cs   = cxu_cs_t'(req_data0[1:0]);

  assign lane_signed = (dp_q == DP_SIGNED) || (dp_q == DP_ACC_SIGNED);
  assign lane_a      = data0_q[int'(beat_q)*LW +: LW];
  assign lane_b      = data1_q[int'(beat_q)*LW +: LW];
  assign mac_result  = sum_q + lane_sum;

  dotprod_lanes #(
    .ELEM_W     (ELEM_W),
    .LANES      (LANES),
    .CXU_DATA_W (CXU_DATA_W)
  ) u_lanes (
    .is_signed (lane_signed),
    .a         (lane_a),
    .b         (lane_b),
    .sum       (lane_sum)
  );

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_status = resp_status_q;
  assign resp_data   = resp_data_q;

  always_comb begin
    state_d       = state_q;
    dp_d          = dp_q;
    ctx_d         = ctx_q;
    data0_d       = data0_q;
    data1_d       = data1_q;
    beat_d        = beat_q;
    sum_d         = sum_q;
    resp_status_d = resp_status_q;
    resp_data_d   = resp_data_q;
    cs_d          = cs_q;
    zacc_d        = zacc_q;
    acc_we        = 1'b0;
    acc_waddr     = ctx_q;
    acc_wdata     = mac_result;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          dp_d          = dotprod_cfid_t'(req_cfid[1:0]);
          ctx_d         = rd_idx;
          data0_d       = req_data0;
          data1_d       = req_data1;
          beat_d        = '0;
          sum_d         = (dp_d == DP_ACC_UNSIGNED || dp_d == DP_ACC_SIGNED) ? acc_rd : '0;
          resp_status_d = CXU_OK;
          resp_data_d   = '0;
          state_d       = ST_RESP;
          if (!state_ok) begin
            resp_status_d = CXU_ERROR_STATE;
          end else if (cs_q[rd_idx] == CXU_CS_OFF &&
                       req_cfid != CXU_CFID_WRITE_STATUS &&
                       req_cfid != CXU_CFID_READ_STATUS) begin
            resp_status_d = CXU_ERROR_OFF;
          end else if (req_cfid < cfid_t'(4)) begin
            state_d = ST_MAC;
          end else begin
            // State/status functions commit here, on the way into RESP.
            case (req_cfid)
              CXU_CFID_WRITE_STATE: begin
                acc_we         = 1'b1;
                acc_waddr      = rd_idx;
                acc_wdata      = req_data0;
                zacc_d[rd_idx] = 1'b0;
                cs_d[rd_idx]   = CXU_CS_DIRTY;
              end
              CXU_CFID_READ_STATE: begin
                resp_data_d = acc_rd;
              end
              CXU_CFID_WRITE_STATUS: begin
                resp_data_d[CSW_W-1:0] = make_csw(cs_q[rd_idx]);
                cs_d[rd_idx]           = new_cs;
                if (new_cs == CXU_CS_OFF || new_cs == CXU_CS_INIT) begin
                  zacc_d[rd_idx] = 1'b1;
                end
              end
              CXU_CFID_READ_STATUS: begin
                resp_data_d[CSW_W-1:0] = make_csw(cs_q[rd_idx]);
              end
              default: begin
                resp_status_d = CXU_ERROR_FUNC;
              end
            endcase
          end
        end
      end
      ST_MAC: begin
        sum_d  = mac_result;
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(B-1)) begin
          acc_we        = 1'b1;
          zacc_d[ctx_q] = 1'b0;
          cs_d[ctx_q]   = CXU_CS_DIRTY;
          resp_data_d   = mac_result;
          resp_status_d = CXU_OK;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      dp_q          <= DP_UNSIGNED;
      ctx_q         <= '0;
      data0_q       <= '0;
      data1_q       <= '0;
      beat_q        <= '0;
      sum_q         <= '0;
      resp_status_q <= CXU_OK;
      resp_data_q   <= '0;
      zacc_q        <= '1;
      for (int i = 0; i < CXU_N_STATES; i++) begin
        cs_q[i] <= CXU_CS_INIT;
      end
    end else if (clk_en) begin
      state_q       <= state_d;
      dp_q          <= dp_d;
      ctx_q         <= ctx_d;
      data0_q       <= data0_d;
      data1_q       <= data1_d;
      beat_q        <= beat_d;
      sum_q         <= sum_d;
      resp_status_q <= resp_status_d;
      resp_data_q   <= resp_data_d;
      zacc_q        <= zacc_d;
      cs_q          <= cs_d;
    end
  end

  // Accumulators carry no reset; zacc masks stale contents after reset.
  always_ff @(posedge clk) begin
    if (!rst && clk_en && acc_we) begin
      acc_q[acc_waddr] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_dotprod_l2_cxu.sv
// tb/tb_dotprod_l2_cxu.sv - directed self-checking bench for dotprod_l2_cxu
module tb_dotprod_l2_cxu;
  import cxu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        req_valid;
  logic        req_ready;
  logic [0:0]  req_cxu;
  logic [2:0]  req_state;
  logic [9:0]  req_func;
  logic [31:0] req_data0;
  logic [31:0] req_data1;
  logic        resp_valid;
  logic        resp_ready;
  cxu_status_t resp_status;
  logic [31:0] resp_data;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dotprod_l2_cxu #(
    .CXU_N_STATES   (4),
    .CXU_DATA_W     (32),
    .ELEM_W         (8),
    .LANES          (2),
    .CXU_STATE_ID_W (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cxu     (req_cxu),
    .req_state   (req_state),
    .req_func    (req_func),
    .req_data0   (req_data0),
    .req_data1   (req_data1),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_status (resp_status),
    .resp_data   (resp_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge with the unit idle and resp_ready high.
  task automatic req_chk(input string tag, input int f, input int s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input cxu_status_t exp_s,
                         input int exp_lat);
    int lat;
    req_func  = 10'(f);
    req_state = 3'(s);
    req_data0 = a;
    req_data1 = b;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, 64'(resp_data), 64'(exp_d));
    check({tag, "_st"}, 64'(resp_status), 64'(exp_s));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rdy"}, 64'(req_ready), 64'd1);
  endtask

  localparam logic [31:0] A1 = 32'h01020304;
  localparam logic [31:0] B1 = 32'h05060708;
  localparam logic [31:0] A2 = 32'hFF020304;

  initial begin
    int n;
    rst        = 1'b1;
    clk_en     = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    req_cxu    = '0;
    req_state  = '0;
    req_func   = '0;
    req_data0  = '0;
    req_data1  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_status", 64'(resp_status), 64'(CXU_OK));
    check("rst_resp_data", 64'(resp_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    req_chk("init_status", 1023, 0, 0, 0, 32'h5, CXU_OK, 1);

    req_chk("t1_dp", 0, 0, A1, B1, 32'h46, CXU_OK, 3);
    req_chk("t1_acc", 1, 0, A1, B1, 32'h8C, CXU_OK, 3);
    req_chk("t1_rd_state", 1021, 0, 0, 0, 32'h8C, CXU_OK, 1);
    req_chk("t1_rd_status", 1023, 0, 0, 0, 32'h7, CXU_OK, 1);

    req_chk("t2_signed", 2, 0, A2, B1, 32'h3C, CXU_OK, 3);
    req_chk("t2_unsigned", 0, 0, A2, B1, 32'h53C, CXU_OK, 3);
    req_chk("t2_acc_signed", 3, 0, A2, B1, 32'h578, CXU_OK, 3);

    req_chk("wr_state", 1020, 2, 32'h100, 0, 32'h0, CXU_OK, 1);
    req_chk("acc_after_wr", 1, 2, A1, B1, 32'h146, CXU_OK, 3);

    req_chk("t3_bad_state", 0, 4, A1, B1, 32'h0, CXU_ERROR_STATE, 1);
    req_chk("t3_bad_func", 7, 0, A1, B1, 32'h0, CXU_ERROR_FUNC, 1);
    req_chk("t3_unchanged", 1021, 0, 0, 0, 32'h578, CXU_OK, 1);

    req_chk("t4_wr_off", 1022, 1, 32'h0, 0, 32'h5, CXU_OK, 1);
    req_chk("t4_dp_off", 0, 1, A1, B1, 32'h0, CXU_ERROR_OFF, 1);
    req_chk("t4_rd_state_off", 1021, 1, 0, 0, 32'h0, CXU_ERROR_OFF, 1);
    req_chk("t4_rd_status_off", 1023, 1, 0, 0, 32'h4, CXU_OK, 1);
    req_chk("t4_wr_init", 1022, 1, 32'h1, 0, 32'h4, CXU_OK, 1);
    req_chk("t4_rd_state_init", 1021, 1, 0, 0, 32'h0, CXU_OK, 1);

    // clk_en low for three cycles in the middle of a MAC
    req_func  = 10'd0;
    req_state = 3'd3;
    req_data0 = A1;
    req_data1 = B1;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    clk_en    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("ce_hold_valid", 64'(resp_valid), 64'd0);
    end
    clk_en = 1'b1;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ce_lat", 64'(n), 64'd2);
    check("ce_data", 64'(resp_data), 64'h46);
    @(posedge clk);
    @(negedge clk);

    // response stall with a request offered during the stall
    resp_ready = 1'b0;
    req_func   = 10'd1021;
    req_state  = 3'd0;
    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_valid0", 64'(resp_valid), 64'd1);
    req_func = 10'd1023;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_stall_valid", 64'(resp_valid), 64'd1);
      check("t5_stall_data", 64'(resp_data), 64'h578);
      check("t5_stall_st", 64'(resp_status), 64'(CXU_OK));
      check("t5_stall_rdy", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("t5_post_hs_rdy", 64'(req_ready), 64'd1);
    check("t5_post_hs_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("t5_next_valid", 64'(resp_valid), 64'd1);
    check("t5_next_data", 64'(resp_data), 64'h7);
    @(posedge clk);
    @(negedge clk);

    // reset in the second MAC beat
    req_func  = 10'd0;
    req_state = 3'd0;
    req_data0 = A1;
    req_data1 = B1;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rdy", 64'(req_ready), 64'd1);
    check("t6_valid", 64'(resp_valid), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("t6_no_resp", 64'(resp_valid), 64'd0);
    end
    for (int c = 0; c < 4; c++) begin
      req_chk("t6_rd_state", 1021, c, 0, 0, 32'h0, CXU_OK, 1);
      req_chk("t6_rd_status", 1023, c, 0, 0, 32'h5, CXU_OK, 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
